seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the team's 16-bit combinational ALU. It keeps the same operand and result shape: two WIDTH-bit operands in, and a 2×WIDTH result split into upper/lower halves plus a zero flag. It adds a valid/ready input handshake, registered outputs, iterative unsigned multiply and divide, and an error flag. It sits between the register-file read stage and write-back in the datapath.

Parameters:
- WIDTH, 16: operand width and width of each result half; legal range 4 to 64.

Ports:
- clk      in   1      clock; all state changes on rising edge
- rst_n    in   1      asynchronous, active-low reset
- in_valid in   1      operation request
- in_ready out  1      block can accept a request (= not busy)
- op       in   4      opcode
- dat1     in   WIDTH  operand A
- dat2     in   WIDTH  operand B
- done     out  1      one-cycle pulse; up/low/ze/err valid from this cycle
- up       out  WIDTH  upper result half
- low      out  WIDTH  lower result half
- ze       out  1      result-zero flag
- err      out  1      illegal opcode or divide-by-zero

Behaviour:
- Reset is asynchronous, active-low, and clock-independent.
  - Reset values: up=0, low=0, ze=0, err=0, done=0, in_ready=1, state IDLE.
  - Reset mid-operation aborts the operation; no done is produced.
- Accept: a request is accepted on a rising edge where in_valid=1 and in_ready=1; op, dat1 and dat2 are latched on that edge. in_valid while in_ready=0 is ignored, not queued.
- States:
  - IDLE: on accept, single-cycle op → DONE; MUL/DIV (divisor ≠ 0) → ITER; DIV by zero → DONE.
  - ITER: bit counter runs 0..WIDTH-1; after the last iteration → DONE.
  - DONE: results registered; done=1 for one cycle; in_ready=1 in this cycle, so back-to-back accepts are allowed (DONE → IDLE, or straight to ITER/DONE on a new accept).
- Latency, counted from the accepting edge: single-cycle ops = 1 cycle; MUL and DIV = WIDTH+1 cycles; divide-by-zero = 1 cycle.
- Opcodes (all arithmetic unsigned, wrap modulo 2^WIDTH; err=0 unless stated):
  - 0 ADD: low = A+B; up = {0…, carry-out}.
  - 1 SUB: low = A−B; up = {0…, borrow}.
  - 2 AND, 3 OR, 4 XOR: bitwise into low; up=0.
  - 5 SLL, 6 SRL, 7 SRA: low = A shifted by B[clog2(WIDTH)-1:0]; up=0.
  - 8 DIV: restoring division; low = quotient, up = remainder. If B=0: low = all ones, up = A, err=1.
  - 9 MUL: shift-add multiply; {up, low} = A×B, full 2×WIDTH product.
  - 10–15 reserved: up=0, low=0, err=1.
- ze = 1 iff {up, low} == 0; updated together with up/low.
- Outputs hold their values between done pulses. up/low/ze/err never change mid-ITER.

Decomposition:
- Package alu_pkg:
  - opcode localparams: OP_ADD … OP_MUL, OP_DIV
  - state enum: IDLE, ITER, DONE
  - function clog2
- One sub-module, seq_alu_muldiv:
  - iterative shift-add / restoring-divide datapath with its counter.
  - start/busy interface; takes WIDTH as a parameter.
- The top level holds the FSM, the single-cycle combinational ops and the output registers.

Test Plan:
1. WIDTH=16, ADD dat1=000F, dat2=0001 → after 1 cycle: done=1, low=0010, up=0000, ze=0, err=0. Then ADD FFFF+0001 → low=0000, up=0001, ze=0.
2. SUB 0A00−00F0 → low=0910, up=0000. SUB 0001−0002 → low=FFFF, up=0001. SUB 1234−1234 → ze=1.
3. MUL 00FF×F0F0 → in_ready=0 for 16 cycles; done exactly 17 cycles after accept; up=00EF, low=FF10. During ITER, in_valid with ADD is ignored.
4. DIV 0A00/00F0 → after 17 cycles: low=000A, up=00A0, err=0. DIV 1234/0000 → after 1 cycle: low=FFFF, up=1234, err=1.
5. Reserved op 4'hF → done after 1 cycle; up=0, low=0, ze=1, err=1. Back-to-back: ADD accepted in the same cycle done=1 completes 1 cycle later.
6. rst_n low during cycle 5 of MUL → outputs immediately 0, in_ready=1, no done. After release, ADD 0003+0004 → low=0007. Repeat directed ops with WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (4-bit)
//   - FSM state type alu_state_t (IDLE, ITER, DONE)
//   - clog2() helper for sizing shift amounts and counters
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Smallest r with 2**r >= value (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle of the sequential ALU.
//   master: drives in_valid, op, dat1, dat2; observes in_ready and results.
//   slave : the ALU.
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both 1; op/dat1/dat2 are captured on that edge. in_valid
// while in_ready=0 is dropped, never queued. done is a one-cycle pulse
// marking up/low/ze/err as newly valid; those hold until the next done.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] dat1;
    logic [WIDTH-1:0] dat2;
    logic             done;
    logic [WIDTH-1:0] up;
    logic [WIDTH-1:0] low;
    logic             ze;
    logic             err;

    modport master (
        output in_valid, op, dat1, dat2,
        input  in_ready, done, up, low, ze, err
    );

    modport slave (
        input  in_valid, op, dat1, dat2,
        output in_ready, done, up, low, ze, err
    );
endinterface

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned multiply / restoring divide, one bit
// per clock, WIDTH iterations.
//   start  : load a, b, is_div and begin (ignored while busy is irrelevant;
//            the parent only pulses it when idle)
//   busy   : iteration in progress
//   last   : the current cycle performs the final iteration
//   res_hi/res_lo : result of the iteration performed this cycle; on the
//            cycle last=1 this is the final {remainder, quotient} or product
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = clog2(WIDTH);

    // hi_q/lo_q: partial product / multiplier for MUL,
    // partial remainder / dividend-becoming-quotient for DIV.
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CW-1:0]    cnt_q;
    logic             div_q, busy_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (div_q) begin
            // Remainder always stays below the divisor, so WIDTH bits suffice.
            if (div_shift >= {1'b0, b_q}) begin
                res_hi = div_diff[WIDTH-1:0];
                res_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                res_hi = div_shift[WIDTH-1:0];
                res_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add-then-shift-right of {carry, hi, lo}.
            res_hi = mul_sum[WIDTH:1];
            res_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign busy = busy_q;
    assign last = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            busy_q <= 1'b0;
        end else if (start) begin
            hi_q   <= '0;
            lo_q   <= a;
            b_q    <= b;
            cnt_q  <= '0;
            div_q  <= is_div;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            hi_q  <= res_hi;
            lo_q  <= res_lo;
            cnt_q <= cnt_q + 1'b1;
            if (last) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready request side and registered
// results.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seq_alu_if slave (in_valid/in_ready/op/dat1/dat2 in,
//                done/up/low/ze/err out)
//   state_dbg  : current FSM state
// Single-cycle ops are computed from the bus on the accepting edge and
// registered straight into the outputs. MUL and non-zero DIV run in
// seq_alu_muldiv; its final iteration result is captured on the same edge
// it is produced, giving WIDTH+1 cycles of latency.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   bus,
    output alu_state_t state_dbg
);
    localparam int SW = clog2(WIDTH);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] up_q, low_q;
    logic             ze_q, err_q;

    logic             accept, is_iter;
    logic             load;
    logic [WIDTH-1:0] up_d, low_d;
    logic             err_d;

    logic [WIDTH:0]   add_w, sub_w;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] s_up, s_low;
    logic             s_err;

    logic             md_start, md_busy, md_last;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign bus.in_ready = (state_q != ITER);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_iter      = (bus.op == OP_MUL) ||
                          ((bus.op == OP_DIV) && (bus.dat2 != '0));

    // Single-cycle datapath. DIV here only covers the divide-by-zero case.
    assign add_w = {1'b0, bus.dat1} + {1'b0, bus.dat2};
    assign sub_w = {1'b0, bus.dat1} - {1'b0, bus.dat2};
    assign sh    = bus.dat2[SW-1:0];

    always_comb begin
        s_up  = '0;
        s_low = '0;
        s_err = 1'b0;
        case (bus.op)
            OP_ADD: begin
                s_low = add_w[WIDTH-1:0];
                s_up  = {{(WIDTH-1){1'b0}}, add_w[WIDTH]};
            end
            OP_SUB: begin
                s_low = sub_w[WIDTH-1:0];
                s_up  = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]};
            end
            OP_AND: s_low = bus.dat1 & bus.dat2;
            OP_OR:  s_low = bus.dat1 | bus.dat2;
            OP_XOR: s_low = bus.dat1 ^ bus.dat2;
            OP_SLL: s_low = bus.dat1 << sh;
            OP_SRL: s_low = bus.dat1 >> sh;
            OP_SRA: s_low = $unsigned($signed(bus.dat1) >>> sh);
            OP_DIV: begin
                s_low = '1;
                s_up  = bus.dat1;
                s_err = 1'b1;
            end
            OP_MUL: s_low = '0;
            default: s_err = 1'b1;
        endcase
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (bus.op == OP_DIV),
        .a      (bus.dat1),
        .b      (bus.dat2),
        .busy   (md_busy),
        .last   (md_last),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    always_comb begin
        state_d  = state_q;
        md_start = 1'b0;
        load     = 1'b0;
        up_d     = s_up;
        low_d    = s_low;
        err_d    = s_err;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (is_iter) begin
                        md_start = 1'b1;
                        state_d  = ITER;
                    end else begin
                        load    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ITER: begin
                if (md_last) begin
                    load    = 1'b1;
                    up_d    = md_hi;
                    low_d   = md_lo;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (!md_busy) begin
                    // Datapath idle without finishing: drop back rather than hang.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            up_q    <= '0;
            low_q   <= '0;
            ze_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                up_q  <= up_d;
                low_q <= low_d;
                ze_q  <= ({up_d, low_d} == '0);
                err_q <= err_d;
            end
        end
    end

    assign bus.done  = (state_q == DONE);
    assign bus.up    = up_q;
    assign bus.low   = low_q;
    assign bus.ze    = ze_q;
    assign bus.err   = err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_state_t st8, st16, st32;

    seq_alu_if #(.WIDTH(8))  i8  ();
    seq_alu_if #(.WIDTH(16)) i16 ();
    seq_alu_if #(.WIDTH(32)) i32 ();

    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8),  .state_dbg(st8));
    seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16), .state_dbg(st16));
    seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(i32), .state_dbg(st32));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    function automatic logic done_of(input int w);
        case (w)
            8:       return i8.done;
            32:      return i32.done;
            default: return i16.done;
        endcase
    endfunction

    // Issues one request (assumes in_ready=1) and waits for done, sampling
    // 1 time unit after each rising edge. lat = cycles from the accept edge.
    task automatic do_op(input int w, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input int max_cyc, output int lat,
                         output logic [63:0] up, output logic [63:0] low,
                         output logic ze, output logic err);
        case (w)
            8:       begin i8.in_valid = 1'b1; i8.op = op; i8.dat1 = a[7:0]; i8.dat2 = b[7:0]; end
            32:      begin i32.in_valid = 1'b1; i32.op = op; i32.dat1 = a[31:0]; i32.dat2 = b[31:0]; end
            default: begin i16.in_valid = 1'b1; i16.op = op; i16.dat1 = a[15:0]; i16.dat2 = b[15:0]; end
        endcase
        @(posedge clk);
        #1;
        i8.in_valid = 1'b0;
        i16.in_valid = 1'b0;
        i32.in_valid = 1'b0;
        lat = 1;
        while (!done_of(w) && lat < max_cyc) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!done_of(w)) begin
            errors++;
            $display("FAIL timeout w=%0d op=%0d: no done within %0d cycles", w, op, max_cyc);
        end
        case (w)
            8:       begin up = 64'(i8.up);  low = 64'(i8.low);  ze = i8.ze;  err = i8.err;  end
            32:      begin up = 64'(i32.up); low = 64'(i32.low); ze = i32.ze; err = i32.err; end
            default: begin up = 64'(i16.up); low = 64'(i16.low); ze = i16.ze; err = i16.err; end
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (i16.up !== 16'h0 || i16.low !== 16'h0 || i16.ze !== 1'b0 || i16.err !== 1'b0 ||
            i16.done !== 1'b0 || i16.in_ready !== 1'b1 || st16 !== IDLE) begin
            errors++;
            $display("FAIL reset16: up=%h low=%h ze=%b err=%b done=%b rdy=%b st=%0d, want 0/0/0/0/0/1/IDLE",
                     i16.up, i16.low, i16.ze, i16.err, i16.done, i16.in_ready, st16);
        end
        checks++;
        if (i8.low !== 8'h0 || i8.done !== 1'b0 || i8.in_ready !== 1'b1 || st8 !== IDLE ||
            i32.low !== 32'h0 || i32.done !== 1'b0 || i32.in_ready !== 1'b1 || st32 !== IDLE) begin
            errors++;
            $display("FAIL reset8_32: low8=%h done8=%b rdy8=%b low32=%h done32=%b rdy32=%b, want 0/0/1 0/0/1",
                     i8.low, i8.done, i8.in_ready, i32.low, i32.done, i32.in_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; logic [63:0] up, low; logic ze, err;
        do_op(16, OP_ADD, 64'h000F, 64'h0001, 5, lat, up, low, ze, err);
        checks++;
        if (lat !== 1 || low !== 64'h0010 || up !== 64'h0 || ze !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL add_000F_0001: lat=%0d up=%h low=%h ze=%b err=%b, want 1 0000 0010 0 0", lat, up, low, ze, err);
        end
        do_op(16, OP_ADD, 64'hFFFF, 64'h0001, 5, lat, up, low, ze, err);
        checks++;
        if (lat !== 1 || low !== 64'h0000 || up !== 64'h0001 || ze !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL add_carry: lat=%0d up=%h low=%h ze=%b err=%b, want 1 0001 0000 0 0", lat, up, low, ze, err);
        end
    endtask

    task automatic test_sub();
        int lat; logic [63:0] up, low; logic ze, err;
        logic [63:0] va [3] = '{64'h0A00, 64'h0001, 64'h1234};
        logic [63:0] vb [3] = '{64'h00F0, 64'h0002, 64'h1234};
        logic [63:0] el [3] = '{64'h0910, 64'hFFFF, 64'h0000};
        logic [63:0] eu [3] = '{64'h0000, 64'h0001, 64'h0000};
        logic        ez [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_op(16, OP_SUB, va[i], vb[i], 5, lat, up, low, ze, err);
            checks++;
            if (lat !== 1 || low !== el[i] || up !== eu[i] || ze !== ez[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL sub[%0d]: lat=%0d up=%h low=%h ze=%b err=%b, want 1 %h %h %b 0",
                         i, lat, up, low, ze, err, eu[i], el[i], ez[i]);
            end
        end
    endtask

    task automatic test_logic_shift();
        int lat; logic [63:0] up, low; logic ze, err;
        logic [3:0]  vo [7] = '{OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SRA};
        logic [63:0] va [7] = '{64'hF0F0, 64'hF0F0, 64'hF0F0, 64'h0001, 64'h8000, 64'h8000, 64'h4000};
        logic [63:0] vb [7] = '{64'hFF00, 64'hFF00, 64'hFF00, 64'h0014, 64'h0004, 64'h000F, 64'h0001};
        logic [63:0] el [7] = '{64'hF000, 64'hFFF0, 64'h0FF0, 64'h0010, 64'h0800, 64'hFFFF, 64'h2000};
        for (int i = 0; i < 7; i++) begin
            do_op(16, vo[i], va[i], vb[i], 5, lat, up, low, ze, err);
            checks++;
            if (lat !== 1 || low !== el[i] || up !== 64'h0 || ze !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL logic_shift[%0d] op=%0d: lat=%0d up=%h low=%h ze=%b err=%b, want 1 0000 %h 0 0",
                         i, vo[i], lat, up, low, ze, err, el[i]);
            end
        end
    endtask

    task automatic test_mul();
        int bad;
        bad = 0;
        i16.in_valid = 1'b1; i16.op = OP_MUL; i16.dat1 = 16'h00FF; i16.dat2 = 16'hF0F0;
        @(posedge clk);
        #1;
        i16.in_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c <= 16 && (i16.in_ready !== 1'b0 || i16.done !== 1'b0 || st16 !== ITER)) bad++;
            if (c == 3) begin
                // ADD offered while busy must be dropped.
                i16.in_valid = 1'b1; i16.op = OP_ADD; i16.dat1 = 16'h0001; i16.dat2 = 16'h0001;
            end
            if (c == 4) i16.in_valid = 1'b0;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mul_busy: %0d busy cycles had in_ready/done/state wrong, want 0", bad);
        end
        checks++;
        if (i16.done !== 1'b1 || i16.in_ready !== 1'b1 || i16.up !== 16'h00EF || i16.low !== 16'hFF10 ||
            i16.ze !== 1'b0 || i16.err !== 1'b0) begin
            errors++;
            $display("FAIL mul_result@17: done=%b rdy=%b up=%h low=%h ze=%b err=%b, want 1 1 00EF FF10 0 0",
                     i16.done, i16.in_ready, i16.up, i16.low, i16.ze, i16.err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (i16.done !== 1'b0 || st16 !== IDLE || i16.low !== 16'hFF10 || i16.up !== 16'h00EF) begin
            errors++;
            $display("FAIL mul_after: done=%b st=%0d up=%h low=%h, want 0 IDLE 00EF FF10 (held)",
                     i16.done, st16, i16.up, i16.low);
        end
    endtask

    task automatic test_div();
        int lat; logic [63:0] up, low; logic ze, err;
        do_op(16, OP_DIV, 64'h0A00, 64'h00F0, 40, lat, up, low, ze, err);
        checks++;
        if (lat !== 17 || low !== 64'h000A || up !== 64'h00A0 || ze !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL div_0A00_00F0: lat=%0d up=%h low=%h ze=%b err=%b, want 17 00A0 000A 0 0", lat, up, low, ze, err);
        end
        do_op(16, OP_DIV, 64'h1234, 64'h0000, 40, lat, up, low, ze, err);
        checks++;
        if (lat !== 1 || low !== 64'hFFFF || up !== 64'h1234 || ze !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL div_by_zero: lat=%0d up=%h low=%h ze=%b err=%b, want 1 1234 FFFF 0 1", lat, up, low, ze, err);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] up, low; logic ze, err;
        do_op(16, 4'hF, 64'h1234, 64'h5678, 5, lat, up, low, ze, err);
        checks++;
        if (lat !== 1 || low !== 64'h0 || up !== 64'h0 || ze !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL reserved_F: lat=%0d up=%h low=%h ze=%b err=%b, want 1 0000 0000 1 1", lat, up, low, ze, err);
        end
        // Issued while done=1 from the reserved op.
        do_op(16, OP_ADD, 64'h0005, 64'h0003, 5, lat, up, low, ze, err);
        checks++;
        if (lat !== 1 || low !== 64'h0008 || up !== 64'h0 || ze !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_add: lat=%0d up=%h low=%h ze=%b err=%b, want 1 0000 0008 0 0", lat, up, low, ze, err);
        end
        do_op(16, 4'hA, 64'h0001, 64'h0001, 5, lat, up, low, ze, err);
        checks++;
        if (lat !== 1 || low !== 64'h0 || up !== 64'h0 || ze !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL reserved_A: lat=%0d up=%h low=%h ze=%b err=%b, want 1 0000 0000 1 1", lat, up, low, ze, err);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; int bad; logic [63:0] up, low; logic ze, err;
        do_op(16, OP_ADD, 64'h000F, 64'h0001, 5, lat, up, low, ze, err);
        i16.in_valid = 1'b1; i16.op = OP_MUL; i16.dat1 = 16'h00FF; i16.dat2 = 16'h0101;
        @(posedge clk);
        #1;
        i16.in_valid = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (i16.up !== 16'h0 || i16.low !== 16'h0 || i16.ze !== 1'b0 || i16.err !== 1'b0 ||
            i16.done !== 1'b0 || i16.in_ready !== 1'b1 || st16 !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_mul: up=%h low=%h ze=%b err=%b done=%b rdy=%b st=%0d, want 0/0/0/0/0/1/IDLE",
                     i16.up, i16.low, i16.ze, i16.err, i16.done, i16.in_ready, st16);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (i16.done !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_no_done: done seen %0d times after aborted MUL, want 0", bad);
        end
        do_op(16, OP_ADD, 64'h0003, 64'h0004, 5, lat, up, low, ze, err);
        checks++;
        if (lat !== 1 || low !== 64'h0007 || up !== 64'h0 || ze !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL add_after_reset: lat=%0d up=%h low=%h ze=%b err=%b, want 1 0000 0007 0 0", lat, up, low, ze, err);
        end
    endtask

    task automatic test_width8();
        int lat; logic [63:0] up, low; logic ze, err;
        logic [3:0]  vo [4] = '{OP_MUL, OP_DIV, OP_SRA, OP_ADD};
        logic [63:0] va [4] = '{64'hFF, 64'hC8, 64'h80, 64'hF0};
        logic [63:0] vb [4] = '{64'hFF, 64'h07, 64'h03, 64'h20};
        logic [63:0] eu [4] = '{64'hFE, 64'h04, 64'h00, 64'h01};
        logic [63:0] el [4] = '{64'h01, 64'h1C, 64'hF0, 64'h10};
        int          ec [4] = '{9, 9, 1, 1};
        for (int i = 0; i < 4; i++) begin
            do_op(8, vo[i], va[i], vb[i], 40, lat, up, low, ze, err);
            checks++;
            if (lat !== ec[i] || up !== eu[i] || low !== el[i] || ze !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL w8[%0d] op=%0d: lat=%0d up=%h low=%h ze=%b err=%b, want %0d %h %h 0 0",
                         i, vo[i], lat, up, low, ze, err, ec[i], eu[i], el[i]);
            end
        end
    endtask

    task automatic test_width32();
        int lat; logic [63:0] up, low; logic ze, err;
        logic [3:0]  vo [4] = '{OP_MUL, OP_DIV, OP_SLL, OP_SUB};
        logic [63:0] va [4] = '{64'h12345678, 64'hFFFFFFFF, 64'h00000001, 64'h00000000};
        logic [63:0] vb [4] = '{64'h00000010, 64'h00000010, 64'h00000025, 64'h00000001};
        logic [63:0] eu [4] = '{64'h00000001, 64'h0000000F, 64'h00000000, 64'h00000001};
        logic [63:0] el [4] = '{64'h23456780, 64'h0FFFFFFF, 64'h00000020, 64'hFFFFFFFF};
        int          ec [4] = '{33, 33, 1, 1};
        for (int i = 0; i < 4; i++) begin
            do_op(32, vo[i], va[i], vb[i], 60, lat, up, low, ze, err);
            checks++;
            if (lat !== ec[i] || up !== eu[i] || low !== el[i] || ze !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL w32[%0d] op=%0d: lat=%0d up=%h low=%h ze=%b err=%b, want %0d %h %h 0 0",
                         i, vo[i], lat, up, low, ze, err, ec[i], eu[i], el[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        i8.in_valid  = 1'b0; i8.op  = 4'h0; i8.dat1  = '0; i8.dat2  = '0;
        i16.in_valid = 1'b0; i16.op = 4'h0; i16.dat1 = '0; i16.dat2 = '0;
        i32.in_valid = 1'b0; i32.op = 4'h0; i32.dat1 = '0; i32.dat2 = '0;

        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_op();
        test_width8();
        test_width32();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
